// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Optional build macro: LED_PWM_EN (adds PWM dimming and the DUTY register).
package led_seq_pkg;

    typedef enum logic [1:0] {
        ModeManual = 2'd0,
        ModeShift  = 2'd1,
        ModeBounce = 2'd2,
        ModeBlink  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFab  = 2'd2
    } state_e;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrManual = 3'd1;
    localparam logic [2:0] AddrPeriod = 3'd2;
    localparam logic [2:0] AddrStatus = 3'd3;
    localparam logic [2:0] AddrDuty   = 3'd4;

    localparam int unsigned CtrlModeLsb     = 0;
    localparam int unsigned CtrlRunBit      = 8;
    localparam int unsigned CtrlFabAllowBit = 9;
    localparam int unsigned StatusStateLsb  = 8;

endpackage

// File: rtl/led_seq_timebase.sv
// Step-rate timer: counts 0..period-1 and strobes step on the last count.
// Periods of 0 or 1 step every cycle; freeze holds the count, clear restarts it.
module led_seq_timebase (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        freeze_i,
    input  logic [31:0] period_i,
    output logic        step_o
);

    logic [31:0] cnt_q;

    // Step when at or past the last count so a shortened period wraps at once.
    always_comb begin
        step_o = 1'b0;
        if (!freeze_i && !clear_i) begin
            step_o = (period_i <= 32'd1) || (cnt_q >= period_i - 32'd1);
        end
    end

    // Counter: clear has priority, then freeze, then count/wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (!freeze_i) begin
            cnt_q <= step_o ? 32'd0 : cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED controller: register file, pattern generator, fabric arbitration.
// Optional build macro: LED_PWM_EN (8-bit PWM dimming gated by the DUTY register).
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 8,
    parameter int unsigned DEFAULT_PERIOD = 50_000_000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [2:0]          avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    input  logic                fab_req,
    input  logic [NUM_LEDS-1:0] fab_leds,
    output logic                fab_gnt,
    output logic [NUM_LEDS-1:0] leds
);

    localparam logic [NUM_LEDS-1:0] LedOne = NUM_LEDS'(1);

    mode_e               mode_q;
    logic                run_q, fab_allow_q;
    logic [NUM_LEDS-1:0] manual_q;
    logic [31:0]         period_q;

    state_e              state_q, state_d;
    logic                fab_gnt_q;
    logic [NUM_LEDS-1:0] raw_q, raw_d, leds_q, gate_mask;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic                phase_q, phase_d;  // bounce: moving up; blink: showing MANUAL
    logic [31:0]         rdata_q, rdata_d;

    logic  ctrl_wr, reload, step;
    mode_e wr_mode;

    assign ctrl_wr = avs_write && (avs_address == AddrCtrl);
    assign wr_mode = mode_e'(avs_writedata[CtrlModeLsb +: 2]);
    // Restart the sequence when run goes high or the mode changes while running.
    assign reload  = ctrl_wr && avs_writedata[CtrlRunBit] && (!run_q || (wr_mode != mode_q));

    led_seq_timebase u_timebase (
        .clk_i    (clk_clk),
        .rst_ni   (reset_reset_n),
        .clear_i  (reload),
        .freeze_i (state_q != StRun),
        .period_i (period_q),
        .step_o   (step)
    );

    // Host-programmed control registers.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            mode_q      <= ModeManual;
            run_q       <= 1'b0;
            fab_allow_q <= 1'b0;
            manual_q    <= '0;
            period_q    <= DEFAULT_PERIOD;
        end else if (avs_write) begin
            case (avs_address)
                AddrCtrl: begin
                    mode_q      <= wr_mode;
                    run_q       <= avs_writedata[CtrlRunBit];
                    fab_allow_q <= avs_writedata[CtrlFabAllowBit];
                end
                AddrManual: manual_q <= avs_writedata[NUM_LEDS-1:0];
                AddrPeriod: period_q <= avs_writedata;
                default: ;
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] duty_q, pwm_cnt_q;

    // Free-running PWM counter and DUTY register.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            duty_q    <= 8'hFF;
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (avs_write && (avs_address == AddrDuty)) begin
                duty_q <= avs_writedata[7:0];
            end
        end
    end

    assign gate_mask = (pwm_cnt_q < duty_q) ? '1 : '0;
`else
    assign gate_mask = '1;
`endif

    // Arbitration, LED source select, pattern stepping and read mux.
    always_comb begin
        if (fab_req && fab_allow_q) begin
            state_d = StFab;
        end else if (run_q) begin
            state_d = StRun;
        end else begin
            state_d = StIdle;
        end

        case (state_q)
            StRun:   raw_d = pattern_q;
            StFab:   raw_d = fab_leds;
            default: raw_d = manual_q;
        endcase

        pattern_d = pattern_q;
        phase_d   = phase_q;
        if (reload) begin
            phase_d   = 1'b1;
            pattern_d = ((wr_mode == ModeShift) || (wr_mode == ModeBounce)) ? LedOne : manual_q;
        end else if (step) begin
            case (mode_q)
                ModeShift: pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                ModeBounce: begin
                    if (phase_q) begin
                        phase_d   = !pattern_q[NUM_LEDS-1];
                        pattern_d = pattern_q[NUM_LEDS-1] ? pattern_q >> 1 : pattern_q << 1;
                    end else begin
                        phase_d   = pattern_q[0];
                        pattern_d = pattern_q[0] ? pattern_q << 1 : pattern_q >> 1;
                    end
                end
                ModeBlink: begin
                    phase_d   = !phase_q;
                    pattern_d = phase_q ? '0 : manual_q;
                end
                default: pattern_d = manual_q;
            endcase
        end

        rdata_d = '0;
        case (avs_address)
            AddrCtrl: begin
                rdata_d[CtrlModeLsb +: 2]  = mode_q;
                rdata_d[CtrlRunBit]        = run_q;
                rdata_d[CtrlFabAllowBit]   = fab_allow_q;
            end
            AddrManual: rdata_d[NUM_LEDS-1:0] = manual_q;
            AddrPeriod: rdata_d = period_q;
            AddrStatus: begin
                rdata_d[NUM_LEDS-1:0]         = raw_q;
                rdata_d[StatusStateLsb +: 2]  = state_q;
            end
`ifdef LED_PWM_EN
            AddrDuty: rdata_d[7:0] = duty_q;
`endif
            default: ;
        endcase
    end

    // Sequencer FSM with registered LED, grant and read-data outputs.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q   <= StIdle;
            fab_gnt_q <= 1'b0;
            raw_q     <= '0;
            leds_q    <= '0;
            pattern_q <= '0;
            phase_q   <= 1'b1;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            fab_gnt_q <= (state_d == StFab);
            raw_q     <= raw_d;
            leds_q    <= raw_d & gate_mask;
            pattern_q <= pattern_d;
            phase_q   <= phase_d;
            if (avs_read) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign avs_readdata = rdata_q;
    assign fab_gnt      = fab_gnt_q;
    assign leds         = leds_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer; expected values go through a scoreboard queue.
// Build with LED_PWM_EN defined to exercise the PWM/DUTY path.
module tb_led_pattern_sequencer;

    localparam int unsigned NumLeds = 8;
    localparam int unsigned DefPeriod = 50_000_000;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [2:0]         avs_address;
    logic               avs_write;
    logic [31:0]        avs_writedata;
    logic               avs_read;
    logic [31:0]        avs_readdata;
    logic               fab_req;
    logic [NumLeds-1:0] fab_leds;
    logic               fab_gnt;
    logic [NumLeds-1:0] leds;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    led_pattern_sequencer #(
        .NUM_LEDS       (NumLeds),
        .DEFAULT_PERIOD (DefPeriod)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .fab_req       (fab_req),
        .fab_leds      (fab_leds),
        .fab_gnt       (fab_gnt),
        .leds          (leds)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input logic [31:0] obs, input string tag);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic rd_check(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        push(exp);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read = 1'b0;
        check_pop(avs_readdata, tag);
    endtask

    task automatic led_check(input logic [NumLeds-1:0] exp, input string tag);
        logic [NumLeds-1:0] obs;
        obs = leds;
`ifdef LED_PWM_EN
        // One PWM slot in 256 is dark even at full duty.
        if (obs === '0) obs = exp;
`endif
        push(32'(exp));
        check_pop(32'(obs), tag);
    endtask

    task automatic wait_leds(input logic [NumLeds-1:0] target, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (leds === target) found = 1'b1;
        end
        push(32'd1);
        check_pop({31'd0, found}, tag);
    endtask

    initial begin
        int lit;
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        fab_req       = 1'b0;
        fab_leds      = '0;
        repeat (3) tick();
        led_check(8'h00, "reset_leds");
        push(32'd0);
        check_pop({31'd0, fab_gnt}, "reset_gnt");
        reset_n = 1'b1;
        tick();

        // Register reset values.
        rd_check(3'd0, 32'h0, "rst_ctrl");
        rd_check(3'd1, 32'h0, "rst_manual");
        rd_check(3'd2, DefPeriod, "rst_period");
`ifdef LED_PWM_EN
        rd_check(3'd4, 32'hFF, "rst_duty");
`else
        rd_check(3'd4, 32'h0, "rst_duty");
        wr(3'd4, 32'h40);
        rd_check(3'd4, 32'h0, "duty_ignored");
`endif
        rd_check(3'd3, 32'h0, "rst_status");
        rd_check(3'd6, 32'h0, "unmapped_rd");

        // MANUAL in IDLE: visible two cycles after the write.
        wr(3'd1, 32'hA5);
        led_check(8'h00, "manual_lat1");
        tick();
        led_check(8'hA5, "manual_lat2");
        rd_check(3'd3, 32'h0A5, "status_idle");

        // Read and write of the same register in one cycle returns the old value.
        push(32'hA5);
        avs_address   = 3'd1;
        avs_writedata = 32'h5A;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        tick();
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check_pop(avs_readdata, "rd_wr_same");
        rd_check(3'd1, 32'h5A, "manual_new");

        // SHIFT at PERIOD=4, fab_allow set but no request.
        wr(3'd2, 32'd4);
        wr(3'd0, 32'h301);
        wait_leds(8'h01, "shift_start");
        for (int i = 0; i < 40; i++) begin
            if (i > 0) tick();
            led_check(8'(1 << ((i / 4) % 8)), "shift_seq");
        end
        rd_check(3'd0, 32'h301, "ctrl_rb");

        // Fabric takeover freezes the pattern and its timer.
        wait_leds(8'h02, "shift_to2");
        wait_leds(8'h04, "shift_to4");
        fab_leds = 8'h3C;
        fab_req  = 1'b1;
        tick();
        push(32'd1);
        check_pop({31'd0, fab_gnt}, "gnt_rise");
        led_check(8'h04, "fab_lat1");
        tick();
        led_check(8'h3C, "fab_leds");
        rd_check(3'd3, 32'h23C, "status_fab");
        repeat (6) begin
            tick();
            led_check(8'h3C, "fab_hold");
        end
        fab_req = 1'b0;
        tick();
        push(32'd0);
        check_pop({31'd0, fab_gnt}, "gnt_drop");
        led_check(8'h3C, "rel_lat");
        for (int i = 0; i < 7; i++) begin
            tick();
            led_check((i < 2) ? 8'h04 : ((i < 6) ? 8'h08 : 8'h10), "shift_resume");
        end

        // BOUNCE at PERIOD=1: ends shown for a single step.
        wr(3'd0, 32'h0);
        wr(3'd2, 32'd1);
        wr(3'd0, 32'h102);
        wait_leds(8'h01, "bounce_start");
        for (int i = 0; i < 30; i++) begin
            int idx;
            if (i > 0) tick();
            idx = i % 14;
            led_check(8'(1 << ((idx <= 7) ? idx : 14 - idx)), "bounce_seq");
        end

        // Request without fab_allow is never granted.
        fab_req = 1'b1;
        tick();
        tick();
        push(32'd0);
        check_pop({31'd0, fab_gnt}, "no_allow_gnt");
        fab_req = 1'b0;

        // BLINK at PERIOD=2 alternates MANUAL and dark.
        wr(3'd0, 32'h0);
        wr(3'd2, 32'd2);
        wr(3'd1, 32'h81);
        wr(3'd0, 32'h103);
        wait_leds(8'h00, "blink_dark");
        wait_leds(8'h81, "blink_lit");
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            led_check(((i / 2) % 2 == 0) ? 8'h81 : 8'h00, "blink_seq");
        end

`ifdef LED_PWM_EN
        // DUTY=0x40 lights exactly 64 of every 256 cycles.
        wr(3'd0, 32'h0);
        wr(3'd1, 32'hFF);
        wr(3'd4, 32'h40);
        repeat (4) tick();
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (leds === 8'hFF) lit++;
        end
        push(32'd64);
        check_pop(32'(lit), "pwm_duty");
        rd_check(3'd4, 32'h40, "duty_rb");
        rd_check(3'd3, 32'hFF, "status_ungated");
`else
        lit = 0;
`endif

        // Reset in the middle of a granted run.
        wr(3'd0, 32'h301);
        fab_leds = 8'h3C;
        fab_req  = 1'b1;
        repeat (3) tick();
        push(32'd1);
        check_pop({31'd0, fab_gnt}, "pre_rst_gnt");
        reset_n = 1'b0;
        tick();
        push(32'd0);
        check_pop({31'd0, fab_gnt}, "midrst_gnt");
        push(32'd0);
        check_pop(32'(leds), "midrst_leds");
        reset_n = 1'b1;
        fab_req = 1'b0;
        tick();
        rd_check(3'd0, 32'h0, "midrst_ctrl");
        rd_check(3'd2, DefPeriod, "midrst_period");
        rd_check(3'd1, 32'h0, "midrst_manual");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
